// File: rtl/mem_scan_pkg.sv
// Shared definitions for the memory scan-capture controller:
// command codes, FSM state encoding and small width helpers.
package mem_scan_pkg;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_CAPTURE = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_scan_ctrl_if.sv
// Read port bundle between the scan controller (master) and one SRAM (slave).
interface mem_scan_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;

  modport master (output req, output addr, input rdata);
  modport slave  (input req, input addr, output rdata);
endinterface

// File: rtl/mem_scan_ctrl_sram.sv
// Single-port behavioural SRAM with byte-lane write enables and a registered
// read port that holds its value between reads. Array contents are not reset.
module sram #(
  parameter int    Depth     = 16,
  parameter int    DataWidth = 8,
  parameter int    ByteWidth = 8,
  parameter string ImplKey   = "default",
  localparam int   AW        = $clog2(Depth),
  localparam int   NB        = DataWidth / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [NB-1:0]        be_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o1
);

  logic [NB-1:0][ByteWidth-1:0] rd_lane;

  // Each byte lane owns its own storage and read register.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [ByteWidth-1:0] lane_mem [Depth];
    logic [ByteWidth-1:0] lane_q;

    always_ff @(posedge clk_i) begin
      if (req_i && we_i && be_i[l])
        lane_mem[addr_i] <= wdata_i[l*ByteWidth +: ByteWidth];
      if (req_i && !we_i)
        lane_q <= lane_mem[addr_i];
    end

    assign rd_lane[l] = lane_q;
  end

  assign rdata_o1 = rd_lane;

endmodule

// File: rtl/mem_scan_ctrl.sv
// Scan-capture controller: on CAPTURE, reads mem0 then mem1 in address order
// and streams each word MSB-first on scan_out_o while freezing the design clock.
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter int Mem0Depth = 16,
  parameter int Mem0Width = 8,
  parameter int Mem1Depth = 8,
  parameter int Mem1Width = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  input  logic [1:0] cmd_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       scan_out_o,
  output logic       scan_valid_o,
  output logic       clk_gate_en_o,
  mem_scan_ctrl_if.master mem0,
  mem_scan_ctrl_if.master mem1
);

  localparam int Mem0AddrWidth = $clog2(Mem0Depth);
  localparam int Mem1AddrWidth = $clog2(Mem1Depth);
  localparam int AW            = max_int(Mem0AddrWidth, Mem1AddrWidth);
  localparam int SW            = max_int(Mem0Width, Mem1Width);
  localparam int CW            = $clog2(SW) + 1;

  scan_state_t   state_q, state_d;
  logic          mem_sel_q;
  logic [AW-1:0] addr_q;
  logic [SW-1:0] sreg_q;
  logic [CW-1:0] bitcnt_q;
  logic          last_bit, last_addr;

  assign last_bit  = (bitcnt_q == '0);
  assign last_addr = mem_sel_q ? (addr_q == AW'(Mem1Depth - 1))
                               : (addr_q == AW'(Mem0Depth - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid_i && cmd_i == CMD_CAPTURE) state_d = ST_READ;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = (last_addr && mem_sel_q) ? ST_DONE : ST_READ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mem_sel_q <= 1'b0;
      addr_q    <= '0;
      sreg_q    <= '0;
      bitcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (state_d == ST_READ) begin
          mem_sel_q <= 1'b0;
          addr_q    <= '0;
        end
        // Narrower words are left-justified so the MSB always sits at sreg[SW-1].
        ST_WAIT: begin
          if (mem_sel_q) begin
            sreg_q   <= SW'(mem1.rdata) << (SW - Mem1Width);
            bitcnt_q <= CW'(Mem1Width - 1);
          end else begin
            sreg_q   <= SW'(mem0.rdata) << (SW - Mem0Width);
            bitcnt_q <= CW'(Mem0Width - 1);
          end
        end
        ST_SHIFT: begin
          sreg_q   <= sreg_q << 1;
          bitcnt_q <= bitcnt_q - CW'(1);
          if (last_bit) begin
            if (!last_addr) begin
              addr_q <= addr_q + AW'(1);
            end else if (!mem_sel_q) begin
              mem_sel_q <= 1'b1;
              addr_q    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_SHIFT);
  assign done_o        = (state_q == ST_DONE);
  assign clk_gate_en_o = ~busy_o;
  assign scan_valid_o  = (state_q == ST_SHIFT);
  assign scan_out_o    = scan_valid_o & sreg_q[SW-1];

  // Addresses are zero whenever the corresponding request is low.
  assign mem0.req  = (state_q == ST_READ) && !mem_sel_q;
  assign mem1.req  = (state_q == ST_READ) &&  mem_sel_q;
  assign mem0.addr = mem0.req ? addr_q[Mem0AddrWidth-1:0] : '0;
  assign mem1.addr = mem1.req ? addr_q[Mem1AddrWidth-1:0] : '0;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Scoreboard bench for mem_scan_ctrl with two attached sram models.
module tb_mem_scan_ctrl;
  import mem_scan_pkg::*;

  localparam int D0 = 16, W0 = 8, D1 = 8, W1 = 16, A0 = 4, A1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic busy, done, scan_out, scan_valid, gate;

  logic          tb_req0 = 1'b0, tb_we0 = 1'b0;
  logic [A0-1:0] tb_a0 = '0;
  logic [W0-1:0] tb_d0 = '0;
  logic          tb_req1 = 1'b0, tb_we1 = 1'b0;
  logic [A1-1:0] tb_a1 = '0;
  logic [W1-1:0] tb_d1 = '0;
  logic [1:0]    tb_be1 = 2'b11;

  mem_scan_ctrl_if #(.AW(A0), .DW(W0)) m0 ();
  mem_scan_ctrl_if #(.AW(A1), .DW(W1)) m1 ();

  mem_scan_ctrl #(.Mem0Depth(D0), .Mem0Width(W0), .Mem1Depth(D1), .Mem1Width(W1)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
    .busy_o(busy), .done_o(done), .scan_out_o(scan_out), .scan_valid_o(scan_valid),
    .clk_gate_en_o(gate), .mem0(m0), .mem1(m1)
  );

  sram #(.Depth(D0), .DataWidth(W0), .ByteWidth(8), .ImplKey("m0")) u_m0 (
    .clk_i(clk), .req_i(m0.req | tb_req0), .we_i(tb_we0),
    .addr_i(tb_req0 ? tb_a0 : m0.addr), .be_i(1'b1), .wdata_i(tb_d0), .rdata_o1(m0.rdata)
  );

  sram #(.Depth(D1), .DataWidth(W1), .ByteWidth(8), .ImplKey("m1")) u_m1 (
    .clk_i(clk), .req_i(m1.req | tb_req1), .we_i(tb_we1),
    .addr_i(tb_req1 ? tb_a1 : m1.addr), .be_i(tb_be1), .wdata_i(tb_d1), .rdata_o1(m1.rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int bits_seen = 0, done_cnt = 0;
  bit exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected bit per presented scan bit.
  always @(negedge clk) begin
    if (!rst) begin
      if (scan_valid) begin
        bits_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scan_bit: unexpected bit %0b with empty scoreboard", scan_out);
        end else begin
          chk("scan_bit", 32'(scan_out), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_drain", exp_q.size(), 0);
      end
    end
  end

  task automatic push_stream();
    logic [7:0]  w8;
    logic [15:0] w16;
    for (int a = 0; a < D0; a++) begin
      w8 = 8'(a);
      for (int b = W0 - 1; b >= 0; b--) exp_q.push_back(w8[b]);
    end
    for (int a = 0; a < D1; a++) begin
      w16 = {8'(a), 8'(a)};
      for (int b = W1 - 1; b >= 0; b--) exp_q.push_back(w16[b]);
    end
  endtask

  task automatic capture();
    cmd_valid = 1'b1;
    cmd = CMD_CAPTURE;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = CMD_NOP;
  endtask

  task automatic wr0(input int a, input logic [7:0] d);
    tb_req0 = 1'b1; tb_we0 = 1'b1; tb_a0 = A0'(a); tb_d0 = d;
    @(negedge clk);
    tb_req0 = 1'b0; tb_we0 = 1'b0;
  endtask

  task automatic wr1(input int a, input logic [15:0] d, input logic [1:0] be);
    tb_req1 = 1'b1; tb_we1 = 1'b1; tb_a1 = A1'(a); tb_d1 = d; tb_be1 = be;
    @(negedge clk);
    tb_req1 = 1'b0; tb_we1 = 1'b0; tb_be1 = 2'b11;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done_o within %0d cycles, got busy=%0b expected done=1", name, c, busy);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctl"}, {25'd0, busy, done, m0.req, m1.req, scan_out, scan_valid, gate}, 32'b1);
    chk({name, "_addr"}, {25'd0, m0.addr, m1.addr}, 32'd0);
  endtask

  initial begin
    int n, gate_bad, c;
    logic [1:0] ign [3];
    ign[0] = 2'd0; ign[1] = 2'd2; ign[2] = 2'd3;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_idle");

    // Standalone SRAM: write, read one cycle later, hold while not reading.
    wr0(3, 8'hA5);
    tb_req0 = 1'b1; tb_we0 = 1'b0; tb_a0 = 4'd3;
    @(negedge clk);
    tb_req0 = 1'b0;
    chk("sram_rd", 32'(m0.rdata), 32'hA5);
    wr0(5, 8'h3C);
    @(negedge clk);
    chk("sram_hold", 32'(m0.rdata), 32'hA5);

    // Preload; mem1 word 2 is assembled through separate byte-lane writes.
    for (int a = 0; a < D0; a++) wr0(a, 8'(a));
    for (int a = 0; a < D1; a++) wr1(a, {8'(a), 8'(a)}, 2'b11);
    wr1(2, 16'hFFFF, 2'b11);
    wr1(2, 16'h0002, 2'b01);
    wr1(2, 16'h0200, 2'b10);

    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd = ign[i];
      @(negedge clk);
      cmd_valid = 1'b0; cmd = CMD_NOP;
      @(negedge clk);
      chk("ignore_cmd", {29'd0, busy, scan_valid, m0.req}, 32'd0);
    end

    // Full capture: busy length, clock gate and stream.
    bits_seen = 0; done_cnt = 0;
    push_stream();
    capture();
    n = 0; gate_bad = 0;
    while (busy && n < 1000) begin
      if (gate !== 1'b0) gate_bad++;
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 304);
    chk("gate_during", gate_bad, 0);
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("gate_after", 32'(gate), 32'd1);
    chk("done_once", 32'(done), 32'd0);
    chk("bits_total", bits_seen, 256);
    chk("done_count", done_cnt, 1);

    // CAPTURE re-issued mid-scan is ignored.
    bits_seen = 0; done_cnt = 0;
    push_stream();
    capture();
    repeat (50) @(negedge clk);
    capture();
    wait_done("recap_done");
    repeat (3) @(negedge clk);
    chk("recap_bits", bits_seen, 256);
    chk("recap_done_cnt", done_cnt, 1);

    // Reset at bit 100.
    bits_seen = 0; done_cnt = 0;
    push_stream();
    capture();
    c = 0;
    while (bits_seen < 100 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    chk("midrst_bits", bits_seen, 100);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("midrst_nodone", done_cnt, 0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Fresh capture after reset yields the full stream.
    bits_seen = 0; done_cnt = 0;
    push_stream();
    capture();
    wait_done("fresh_done");
    repeat (3) @(negedge clk);
    chk("fresh_bits", bits_seen, 256);
    chk("fresh_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
